mmio_controller: RTL

Memory-mapped I/O controller for the Riscv151 core. Sits between the CPU data-memory port (address bit 31 set) and the on-chip I/O resources: UART ready/valid channels, the cycle and instruction counters, the button-event FIFO, the switches and the LEDs. Decodes each access and returns read data with one-cycle latency. Owns every side effect of I/O accesses: UART handshake pulses, FIFO pop, counter reset.

---
 rtl/mmio_controller.sv | 117 +++++++++++
 1 files changed

// File: rtl/mmio_controller.sv
// Memory-mapped I/O block for the Riscv151 data port: decodes offset [7:0],
// returns registered read data one cycle later and owns every I/O side effect.
module mmio_controller #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mmio_addr,
    input  logic        mmio_re,
    input  logic [3:0]  mmio_we,
    input  logic [31:0] mmio_wdata,
    output logic [31:0] mmio_rdata,
    input  logic        inst_retire,
    input  logic        uart_tx_ready,
    output logic        uart_tx_valid,
    output logic [7:0]  uart_tx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic [2:0]  clean_buttons,
    input  logic [1:0]  switches,
    output logic [5:0]  leds
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [7:0]  offs;
    logic        wr, rd;
    logic        rx_pop, fifo_pop_req, tx_wr, cnt_clr, led_wr;
    logic [31:0] cycle_cnt, inst_cnt;
    logic [31:0] rd_mux;

    logic [2:0]  btn_prev, btn_edges;
    logic [2:0]  fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full, fifo_do_push, fifo_do_pop;
    logic [2:0]  fifo_head;

    // Only the low address byte and the low data byte are meaningful here.
    logic unused_bits;
    assign unused_bits = ^{mmio_addr[31:8], mmio_wdata[31:8]};

    assign offs = mmio_addr[7:0];
    // A write in the same cycle as a read wins; the read then has no side effect.
    assign wr = |mmio_we;
    assign rd = mmio_re & ~wr;

    assign rx_pop       = rd && (offs == 8'h04);
    assign fifo_pop_req = rd && (offs == 8'h24);
    assign tx_wr        = wr && (offs == 8'h08);
    assign cnt_clr      = wr && (offs == 8'h18);
    assign led_wr       = wr && (offs == 8'h30);

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_head  = fifo_empty ? 3'b000 : fifo_mem[rd_ptr[AW-1:0]];

    assign btn_edges    = clean_buttons & ~btn_prev;
    assign fifo_do_pop  = fifo_pop_req & ~fifo_empty;
    // A pop frees the head slot at the same edge, so a full FIFO still accepts.
    assign fifo_do_push = (|btn_edges) & (~fifo_full | fifo_do_pop);

    always_comb begin
        rd_mux = 32'h0;
        case (offs)
            8'h00:   rd_mux = {30'b0, uart_rx_valid, uart_tx_ready};
            8'h04:   rd_mux = {24'b0, uart_rx_data};
            8'h10:   rd_mux = cycle_cnt;
            8'h14:   rd_mux = inst_cnt;
            8'h20:   rd_mux = {31'b0, fifo_empty};
            8'h24:   rd_mux = {29'b0, fifo_head};
            8'h28:   rd_mux = {30'b0, switches};
            8'h30:   rd_mux = {26'b0, leds};
            default: rd_mux = 32'h0;
        endcase
    end

    // uart_tx_valid and uart_rx_ready are one-cycle pulses raised at the edge
    // that accepts the access; the UART samples them while high, with no hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mmio_rdata    <= 32'h0;
            uart_tx_valid <= 1'b0;
            uart_tx_data  <= 8'h0;
            uart_rx_ready <= 1'b0;
            leds          <= 6'h0;
            cycle_cnt     <= 32'h0;
            inst_cnt      <= 32'h0;
            btn_prev      <= 3'b000;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
        end else begin
            if (mmio_re) mmio_rdata <= wr ? 32'h0 : rd_mux;

            uart_tx_valid <= tx_wr & uart_tx_ready;
            if (tx_wr && uart_tx_ready) uart_tx_data <= mmio_wdata[7:0];
            uart_rx_ready <= rx_pop & uart_rx_valid;

            if (led_wr) leds <= mmio_wdata[5:0];

            cycle_cnt <= cnt_clr ? 32'h0 : cycle_cnt + 32'd1;
            if (cnt_clr)          inst_cnt <= 32'h0;
            else if (inst_retire) inst_cnt <= inst_cnt + 32'd1;

            btn_prev <= clean_buttons;
            if (fifo_do_push) wr_ptr <= wr_ptr + PW'(1);
            if (fifo_do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_do_push) fifo_mem[wr_ptr[AW-1:0]] <= btn_edges;
    end

endmodule
